// File: rtl/hash_blk_tx_if.sv
// Handshake and status bundle between the hash block transmitter and its
// surroundings: payload input, generator issue/ack, error and shadow-hash outputs.
interface hash_blk_tx_if #(
  parameter int unsigned LEN_W = 8
);
  logic [127:0]     in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [LEN_W-1:0] blk_len_i;
  logic [127:0]     tx_data_o;
  logic             tx_valid_o;
  logic             tx_ack_i;
  logic             clr_err_i;
  logic             busy_o;
  logic             err_timeout_o;
  logic [127:0]     exp_hash_o;
  logic             exp_hash_valid_o;

  // Transmitter side
  modport slave (
    input  in_data_i, in_valid_i, blk_len_i, tx_ack_i, clr_err_i,
    output in_ready_o, tx_data_o, tx_valid_o, busy_o, err_timeout_o,
    output exp_hash_o, exp_hash_valid_o
  );

  // Source / generator / system side
  modport master (
    output in_data_i, in_valid_i, blk_len_i, tx_ack_i, clr_err_i,
    input  in_ready_o, tx_data_o, tx_valid_o, busy_o, err_timeout_o,
    input  exp_hash_o, exp_hash_valid_o
  );
endinterface

// File: rtl/hash_blk_tx.sv
// Hash block transmitter: frames payload words into blocks (bit 9 = start,
// bit 8 = end), issues each word as a one-cycle pulse, waits for the ack and
// keeps a shadow of the hash the generator is expected to produce.
module hash_blk_tx #(
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  hash_blk_tx_if.slave bus
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned TMR_W  = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  hash_q, hash_d;
  logic               hash_vld_q, hash_vld_d;

  logic [LEN_W-1:0]   blk_nz;
  logic [LEN_W-1:0]   eff_len;
  logic               start;
  logic               last;

  // A zero block length means a single-word block
  assign blk_nz = (bus.blk_len_i == '0) ? LEN_W'(1) : bus.blk_len_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, framing, ack/timeout handling and shadow-hash update
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    hash_d     = hash_q;
    hash_vld_d = 1'b0;
    err_d      = err_q & ~bus.clr_err_i;
    start      = 1'b0;
    last       = 1'b0;
    eff_len    = len_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          start   = (word_cnt_q == '0);
          eff_len = start ? blk_nz : len_q;
          if (start) len_d = blk_nz;
          last       = (word_cnt_q == eff_len - LEN_W'(1));
          tx_data_d    = bus.in_data_i;
          tx_data_d[9] = start;
          tx_data_d[8] = last;
          tx_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_ack_i) begin
          hash_d = tx_data_q[9] ? tx_data_q
                                : tx_data_q ^ {hash_q[DATA_W-2:0], hash_q[DATA_W-1]};
          if (tx_data_q[8]) begin
            hash_vld_d = 1'b1;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + LEN_W'(1);
          end
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          // Abort the block; the shadow hash is left as it was
          if (timer_d == TMR_W'(ACK_TIMEOUT - 1)) begin
            err_d      = 1'b1;
            word_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      hash_q     <= '0;
      hash_vld_q <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      hash_q     <= hash_d;
      hash_vld_q <= hash_vld_d;
    end
  end

  assign bus.in_ready_o       = (state_q == IDLE);
  assign bus.busy_o           = (state_q != IDLE) || (word_cnt_q != '0);
  assign bus.tx_data_o        = tx_data_q;
  assign bus.tx_valid_o       = tx_valid_q;
  assign bus.err_timeout_o    = err_q;
  assign bus.exp_hash_o       = hash_q;
  assign bus.exp_hash_valid_o = hash_vld_q;

endmodule

// File: tb/tb_hash_blk_tx.sv
// Randomized scoreboard bench for hash_blk_tx.
module tb_hash_blk_tx;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ACK_TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hash_blk_tx_if #(.LEN_W(LEN_W)) bus ();

  hash_blk_tx #(.LEN_W(LEN_W), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] tx_q[$];
  logic [127:0] hash_q[$];
  int           ack_plan[$];
  int           valid_log[$];
  int           err_exp = 0;
  int           last_valid_cyc = -100;

  // Reference model state: position in block, block length, running hash
  int           m_cnt  = 0;
  int           m_len  = 1;
  logic [127:0] m_hash = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [127:0] rotl1(input logic [127:0] v);
    return (v << 1) | (v >> 127);
  endfunction

  // Expected framing/hash of one word given its ack plan (0 = never acked)
  task automatic model_word(input logic [127:0] data, input int blk, input int d);
    logic [127:0] f;
    bit st, en;
    st = (m_cnt == 0);
    if (st) m_len = (blk == 0) ? 1 : blk;
    en = (m_cnt == m_len - 1);
    f = data;
    f[9] = st;
    f[8] = en;
    tx_q.push_back(f);
    if (d == 0) begin
      m_cnt = 0;
      err_exp++;
    end else begin
      m_hash = st ? f : (f ^ rotl1(m_hash));
      if (en) begin
        hash_q.push_back(m_hash);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return just after the edge that accepted it
  task automatic send_word(input logic [127:0] data, input int blk, input int d, input bit hold);
    bit r;
    int guard;
    ack_plan.push_back(d);
    bus.in_data_i  = data;
    bus.blk_len_i  = LEN_W'(blk);
    bus.in_valid_i = 1'b1;
    guard = 0;
    do begin
      r = bus.in_ready_o;
      step();
      guard++;
    end while (!r && guard < 100);
    if (!r) fail_now("accept_wait");
    if (!hold) bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((tx_q.size() != 0 || hash_q.size() != 0 || err_exp != 0 || !bus.in_ready_o) && g < 300) begin
      step();
      g++;
    end
    if (g >= 300) fail_now("drain_wait");
  endtask

  // After a never-acked word: wait for the timeout flag and clear it
  task automatic handle_timeout();
    int g;
    bit clr_hold;
    clr_hold = ($urandom_range(0, 1) == 1);
    if (clr_hold) bus.clr_err_i = 1'b1;
    g = 0;
    while (!bus.err_timeout_o && g < 40) begin
      step();
      g++;
    end
    check("err_raised", bus.err_timeout_o, 1'b1);
    step();
    if (clr_hold) begin
      check("err_cleared_after_set_wins", bus.err_timeout_o, 1'b0);
      bus.clr_err_i = 1'b0;
    end else begin
      check("err_sticky", bus.err_timeout_o, 1'b1);
      bus.clr_err_i = 1'b1;
      step();
      bus.clr_err_i = 1'b0;
      check("err_cleared", bus.err_timeout_o, 1'b0);
    end
  endtask

  // Generator model: acks d cycles after each valid, plus spurious acks in IDLE/ISSUE
  initial begin
    int cnt;
    int d;
    cnt = 0;
    bus.tx_ack_i = 1'b0;
    forever begin
      step();
      bus.tx_ack_i = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (bus.tx_valid_o) begin
        d = (ack_plan.size() != 0) ? ack_plan.pop_front() : 1;
        cnt = d;
        bus.tx_ack_i = ($urandom_range(0, 3) == 0);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_ack_i = 1'b1;
      end else if (bus.in_ready_o && $urandom_range(0, 3) == 0) begin
        bus.tx_ack_i = 1'b1;
      end
    end
  end

  // Monitor: compares every issued word, hash pulse and timeout rise
  initial begin
    bit err_prev;
    err_prev = 1'b0;
    forever begin
      step();
      if (rst) begin
        err_prev = 1'b0;
        last_valid_cyc = -100;
      end else begin
        if (bus.tx_valid_o) begin
          if (tx_q.size() == 0) fail_now("tx_unexpected");
          else check("tx_data", bus.tx_data_o, tx_q.pop_front());
          check("tx_spacing_ge3", ((cyc - last_valid_cyc) >= 3), 1'b1);
          last_valid_cyc = cyc;
          valid_log.push_back(cyc);
        end
        if (bus.exp_hash_valid_o) begin
          if (hash_q.size() == 0) fail_now("hash_unexpected");
          else check("exp_hash", bus.exp_hash_o, hash_q.pop_front());
        end
        if (bus.err_timeout_o && !err_prev) begin
          check("err_latency", cyc - last_valid_cyc, ACK_TO);
          check("err_expected", (err_exp > 0), 1'b1);
          if (err_exp > 0) err_exp--;
          check("busy_after_timeout", bus.busy_o, 1'b0);
        end
        err_prev = bus.err_timeout_o;
      end
    end
  end

  initial begin
    #1_000_000;
    fail_now("global_watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    logic [127:0] f;
    int d, blk, n;
    bit hold;

    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.blk_len_i  = '0;
    bus.clr_err_i  = 1'b0;
    repeat (3) step();
    check("rst_in_ready", bus.in_ready_o, 1'b1);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_tx_valid", bus.tx_valid_o, 1'b0);
    check("rst_tx_data", bus.tx_data_o, '0);
    check("rst_err", bus.err_timeout_o, 1'b0);
    check("rst_exp_hash", bus.exp_hash_o, '0);
    check("rst_exp_hash_valid", bus.exp_hash_valid_o, 1'b0);
    rst = 1'b0;
    step();

    // Three-word block with ack one cycle after each issue
    tx_q.push_back(128'h201);
    tx_q.push_back(128'h002);
    tx_q.push_back(128'h104);
    hash_q.push_back(128'h904);
    m_cnt = 0;
    m_hash = 128'h904;
    send_word(128'h1, 3, 1, 1'b1);
    send_word(128'h2, 7, 1, 1'b1);
    send_word(128'h4, 0, 1, 1'b0);
    wait_drain();
    n = valid_log.size();
    check("tp1_spacing_a", valid_log[n-2] - valid_log[n-3], 3);
    check("tp1_spacing_b", valid_log[n-1] - valid_log[n-2], 3);

    // Zero length means a single-word block
    tx_q.push_back(128'hFFFF_0300);
    hash_q.push_back(128'hFFFF_0300);
    m_hash = 128'hFFFF_0300;
    send_word(128'hFFFF_0000, 0, 1, 1'b0);
    wait_drain();
    check("tp2_exp_hash_hold", bus.exp_hash_o, 128'hFFFF_0300);
    check("tp2_tx_data_hold", bus.tx_data_o, 128'hFFFF_0300);

    // Timeout on a never-acked single word, then a fresh block start
    model_word(128'hABCD_0000, 1, 0);
    send_word(128'hABCD_0000, 1, 0, 1'b0);
    handle_timeout();
    wait_drain();

    // Reset during the ack wait of word 2 of a 4-word block
    w = {$urandom, $urandom, $urandom, $urandom};
    model_word(w, 4, 1);
    send_word(w, 4, 1, 1'b0);
    w = {$urandom, $urandom, $urandom, $urandom};
    f = w;
    f[9:8] = 2'b00;
    tx_q.push_back(f);
    send_word(w, 9, 0, 1'b0);
    repeat (4) step();
    check("pre_rst_busy", bus.busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_data", bus.tx_data_o, '0);
    check("mid_rst_tx_valid", bus.tx_valid_o, 1'b0);
    check("mid_rst_exp_hash", bus.exp_hash_o, '0);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_in_ready", bus.in_ready_o, 1'b1);
    check("mid_rst_err", bus.err_timeout_o, 1'b0);
    step();
    rst = 1'b0;
    m_cnt = 0;
    m_hash = '0;
    w = {$urandom, $urandom, $urandom, $urandom};
    model_word(w, 2, 1);
    send_word(w, 2, 1, 1'b0);
    w = {$urandom, $urandom, $urandom, $urandom};
    model_word(w, 5, 1);
    send_word(w, 5, 1, 1'b0);
    wait_drain();

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      w   = {$urandom, $urandom, $urandom, $urandom};
      blk = $urandom_range(0, 5);
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = ACK_TO - 1;
        2:       d = 2;
        3:       d = 3;
        default: d = 1;
      endcase
      hold = (d != 0) && ($urandom_range(0, 2) != 0);
      model_word(w, blk, d);
      send_word(w, blk, d, hold);
      if (d == 0) begin
        handle_timeout();
      end else if (!hold) begin
        repeat ($urandom_range(0, 3)) step();
      end
    end
    bus.in_valid_i = 1'b0;
    wait_drain();
    repeat (5) step();

    check("final_tx_q_empty", tx_q.size(), 0);
    check("final_hash_q_empty", hash_q.size(), 0);
    check("final_err_exp", err_exp, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
